perceptron_seq_ctrl: RTL and testbench
======================================

// Module: perceptron_seq_ctrl
// PURPOSE
//  Sequencer for a single-layer perceptron neuron. Accepts an N-bit binary input vector over a valid/ready handshake.
//  Accumulates the selected weights one element per cycle into a single 32-bit saturating accumulator, then thresholds the sum.
//  Optionally applies the perceptron learning rule to its internal weight bank before presenting the result.
//  Sits between the input stream source and the neuron output consumer; owns the weight register bank and its load port.
// PARAMETERS
//  N       8   number of inputs / weights (>=2)
//  W       32  weight and accumulator width, signed two's complement
//  THRESH  0   signed threshold; out_y = (sum > THRESH)
//  LR      1   signed learning-rate step added/subtracted per weight update
// PORTS
//  clk       in   1        rising-edge clock
//  rst_n     in   1        asynchronous active-low reset
//  in_valid  in   1        input vector valid
//  in_ready  out  1        block can accept a vector (high only in IDLE)
//  in_x      in   N        binary input vector; bit i selects weight i
//  in_train  in   1        apply learning rule to this vector
//  in_target in   1        desired output for training
//  wr_en     in   1        weight load strobe
//  wr_addr   in   clog2(N) weight index
//  wr_data   in   W        weight value
//  wr_drop   out  1        1-cycle pulse: wr_en ignored (not IDLE)
//  out_valid out  1        result valid, held until out_ready
//  out_ready in   1        consumer accepts result
//  out_sum   out  W        saturated weighted sum (pre-update weights)
//  out_y     out  1        thresholded output
//  out_ovf   out  1        sum saturated at least once in this transaction
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, all weights=0, acc=0, idx=0, out_valid=0, out_sum=0, out_y=0, out_ovf=0, wr_drop=0.
//    in_ready is (state==IDLE), so it reads 1 during and after reset. Asserting reset mid-transaction aborts it; no output is produced.
//  States: IDLE -> ACCUM -> [UPDATE] -> OUT -> IDLE.
//  IDLE: in_ready=1. Accept on in_valid&&in_ready edge:
//    latch in_x/in_train/in_target; acc<=0; idx<=0; ovf<=0; go ACCUM.
//    wr_en in IDLE: w[wr_addr]<=wr_data at the edge. wr_addr>=N is ignored.
//    wr_en and accept in the same cycle: the write lands first; the new vector uses the new weight.
//  ACCUM: N edges, idx 0..N-1.
//    acc <= sat(acc + (x[idx] ? w[idx] : 0)).
//    On the idx==N-1 edge: out_sum<=final acc; out_y<=(final acc > THRESH), signed compare.
//      Next state is UPDATE if train && y!=target, else OUT.
//  UPDATE: N edges, idx 0..N-1.
//    If x[idx]: w[idx] <= sat(w[idx] + (target ? +LR : -LR)). Weights with x[idx]=0 are unchanged.
//    After idx==N-1: go OUT.
//  OUT: out_valid=1. out_sum, out_y, out_ovf stay stable until the out_valid&&out_ready edge, then go IDLE.
//    in_ready=0 in OUT, so there is a minimum of one bubble cycle between transactions.
//  Latency (accept edge to out_valid high): N cycles with no update; 2N cycles with an update.
//  Saturation: signed W-bit add.
//    Positive overflow clamps to 0x7FFF_FFFF; negative overflow clamps to 0x8000_0000.
//    ovf is sticky for the transaction (accumulator only); weight saturation does not set it.
//  wr_en outside IDLE: the weight is unchanged and wr_drop pulses high for one cycle.
//  in_valid while not ready: ignored; the source must hold its data.
// TESTING (N=8, THRESH=0, LR=1)
//  1. Load w[i]=i+1, send x=8'hFF, train=0 -> out_valid 8 cycles after accept, out_sum=36, out_y=1, out_ovf=0.
//  2. Same weights, x=8'h00 -> out_sum=0, out_y=0; x=8'h81 -> out_sum=9, out_y=1.
//  3. All w=32'h4000_0000, x=8'hFF -> out_sum=32'h7FFF_FFFF, out_ovf=1.
//     All w=32'hC000_0000 -> out_sum=32'h8000_0000, out_ovf=1.
//  4. Weights 0, x=8'h05, train=1, target=1 -> out_valid 16 cycles after accept, out_sum=0, out_y=0.
//     Then x=8'h05, train=0 -> out_sum=2, out_y=1 (w0=w2=1).
//     Repeat with train=1, target=1 -> no update, latency 8.
//  5. Hold out_ready=0 for 5 cycles in OUT -> out_valid and outputs stable, in_ready=0.
//     wr_en during ACCUM -> wr_drop pulse, later sum unaffected.
//  6. Pull rst_n low mid-ACCUM (idx=3) -> out_valid=0 and in_ready=1 immediately.
//     Next vector with x=8'hFF -> out_sum=0 (weights cleared).

Source files
------------

// File: rtl/perceptron_seq_ctrl.sv
// Single-layer perceptron sequencer: serial weighted sum over a binary input
// vector, threshold, optional learning-rule weight update, result handshake.

module perceptron_wcell #(
  parameter int W  = 32,
  parameter int LR = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         upd_en,
  input  logic         upd_up,
  output logic [W-1:0] w
);
  logic [W-1:0] step, sum, sat;
  logic         ov;

  assign step = upd_up ? W'(LR) : W'(-LR);
  assign sum  = w + step;
  assign ov   = (w[W-1] == step[W-1]) && (sum[W-1] != w[W-1]);
  // Clamp toward the sign of the operands on overflow.
  assign sat  = ov ? {w[W-1], {(W-1){~w[W-1]}}} : sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      w <= '0;
    else if (wr_en)  w <= wr_data;
    else if (upd_en) w <= sat;
  end
endmodule

module perceptron_seq_ctrl #(
  parameter  int N      = 8,
  parameter  int W      = 32,
  parameter  int THRESH = 0,
  parameter  int LR     = 1,
  localparam int AW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_x,
  input  logic          in_train,
  input  logic          in_target,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  output logic          wr_drop,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic          out_y,
  output logic          out_ovf
);
  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, OUT} state_t;

  state_t              state, state_nxt;
  logic [AW-1:0]       idx;
  logic [N-1:0]        x_q;
  logic                train_q, target_q;
  logic [W-1:0]        acc, addend, acc_sum, acc_sat;
  logic                acc_ov, ovf, y_new, accept, last;
  logic [N-1:0][W-1:0] w;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign out_ovf   = ovf;
  assign accept    = in_valid && in_ready;
  assign last      = (idx == AW'(N-1));

  assign addend  = x_q[idx] ? w[idx] : '0;
  assign acc_sum = acc + addend;
  assign acc_ov  = (acc[W-1] == addend[W-1]) && (acc_sum[W-1] != acc[W-1]);
  assign acc_sat = acc_ov ? {acc[W-1], {(W-1){~acc[W-1]}}} : acc_sum;
  assign y_new   = $signed(acc_sat) > $signed(W'(THRESH));

  // Writes are only honoured in IDLE; out-of-range addresses match no cell.
  for (genvar i = 0; i < N; i++) begin : g_w
    perceptron_wcell #(.W(W), .LR(LR)) u_w (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en && in_ready && (wr_addr == AW'(i))),
      .wr_data (wr_data),
      .upd_en  ((state == UPDATE) && (idx == AW'(i)) && x_q[i]),
      .upd_up  (target_q),
      .w       (w[i])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCUM;
      ACCUM:   if (last) state_nxt = (train_q && (y_new != target_q)) ? UPDATE : OUT;
      UPDATE:  if (last) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      x_q      <= '0;
      train_q  <= 1'b0;
      target_q <= 1'b0;
      acc      <= '0;
      ovf      <= 1'b0;
      out_sum  <= '0;
      out_y    <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      wr_drop <= wr_en && (state != IDLE);
      case (state)
        IDLE: if (accept) begin
          x_q      <= in_x;
          train_q  <= in_train;
          target_q <= in_target;
          acc      <= '0;
          idx      <= '0;
          ovf      <= 1'b0;
        end
        ACCUM: begin
          acc <= acc_sat;
          if (acc_ov) ovf <= 1'b1;
          if (last) begin
            idx     <= '0;
            out_sum <= acc_sat;
            out_y   <= y_new;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        UPDATE:  idx <= last ? '0 : idx + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_perceptron_seq_ctrl.sv
// Directed bench for perceptron_seq_ctrl: driver queues expected results,
// a negedge monitor pops and compares when out_valid first appears.

module tb_perceptron_seq_ctrl;
  localparam int N = 8;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_train, in_target;
  logic [N-1:0] in_x;
  logic         wr_en, wr_drop;
  logic [2:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic         out_valid, out_ready, out_y, out_ovf;
  logic [W-1:0] out_sum;

  perceptron_seq_ctrl #(.N(N), .W(W), .THRESH(0), .LR(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_train(in_train), .in_target(in_target),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_y(out_y), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         y;
    logic         ovf;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   seen  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got sum %0h want no output", out_sum);
        end else begin
          mon_e = q.pop_front();
          chk("out_sum", out_sum, mon_e.sum);
          chk("out_y", 32'(out_y), 32'(mon_e.y));
          chk("out_ovf", 32'(out_ovf), 32'(mon_e.ovf));
          chk("latency", cyc - mon_e.acc_cyc, mon_e.lat);
        end
      end
      if (out_valid && out_ready) seen = 1'b0;
    end
  end

  task automatic wr_w(input logic [2:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] x, input logic tr, input logic tg,
                      input logic [W-1:0] s, input logic y, input logic ov,
                      input int lat, input bit push);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL in_ready_timeout: got 0 want 1");
      return;
    end
    in_x = x; in_train = tr; in_target = tg; in_valid = 1'b1;
    e.sum = s; e.y = y; e.ovf = ov; e.lat = lat; e.acc_cyc = cyc + 1;
    if (push) q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 300) begin @(negedge clk); n++; end
    if (q.size() != 0 || !in_ready) begin
      total++; bad++;
      $display("FAIL idle_timeout: got pending=%0d want 0", q.size());
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_train = 1'b0; in_target = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    chk("rst_wr_drop", 32'(wr_drop), 0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);

    // Basic sums with w[i] = i+1
    for (int i = 0; i < N; i++) wr_w(3'(i), 32'(i + 1));
    send(8'hFF, 0, 0, 36, 1, 0, 8, 1);
    send(8'h00, 0, 0, 0,  0, 0, 8, 1);
    send(8'h81, 0, 0, 9,  1, 0, 8, 1);

    // Backpressure hold and dropped write during ACCUM
    wait_idle();
    out_ready = 1'b0;
    send(8'hFF, 0, 0, 36, 1, 0, 8, 1);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'd1000;
    @(negedge clk); wr_en = 1'b0;
    chk("wr_drop_pulse", 32'(wr_drop), 1);
    @(negedge clk);
    chk("wr_drop_clear", 32'(wr_drop), 0);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_sum", out_sum, 36);
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    send(8'h01, 0, 0, 1, 1, 0, 8, 1);

    // Saturation both directions
    wait_idle();
    for (int i = 0; i < N; i++) wr_w(3'(i), 32'h4000_0000);
    send(8'hFF, 0, 0, 32'h7FFF_FFFF, 1, 1, 8, 1);
    wait_idle();
    for (int i = 0; i < N; i++) wr_w(3'(i), 32'hC000_0000);
    send(8'hFF, 0, 0, 32'h8000_0000, 0, 1, 8, 1);

    // Training
    wait_idle();
    for (int i = 0; i < N; i++) wr_w(3'(i), 32'h0);
    send(8'h05, 1, 1, 0, 0, 0, 16, 1);
    send(8'h05, 0, 0, 2, 1, 0, 8,  1);
    send(8'h05, 1, 1, 2, 1, 0, 8,  1);

    // Abort mid-ACCUM via reset; weights must be cleared
    wait_idle();
    for (int i = 0; i < N; i++) wr_w(3'(i), 32'(i + 1));
    send(8'hFF, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    send(8'hFF, 0, 0, 0, 0, 0, 8, 1);

    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
